// File: rtl/approx_adder_error_monitor.sv
// Exhaustive sweep driver and error monitor for a combinational approximate adder.
// Applies every input vector once, compares against the exact sum and accumulates error metrics.
module approx_adder_error_monitor #(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 3,
    parameter int ET       = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [IN_BITS-1:0]           dut_in,
    input  logic [OUT_BITS-1:0]          dut_out,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [OUT_BITS-1:0]          max_err,
    output logic [IN_BITS:0]             err_count,
    output logic [IN_BITS+OUT_BITS-1:0]  err_sum,
    output logic [IN_BITS-1:0]           first_fail,
    output logic                         any_fail
);

    localparam int          OP_BITS = IN_BITS / 2;
    localparam int          SUM_W   = IN_BITS + OUT_BITS;
    localparam logic [31:0] ET_U    = 32'(ET);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IN_BITS-1:0]      vec_q, vec_d;
    logic [OUT_BITS-1:0]     max_err_q, max_err_d;
    logic [IN_BITS:0]        err_count_q, err_count_d;
    logic [SUM_W-1:0]        err_sum_q, err_sum_d;
    logic [IN_BITS-1:0]      first_fail_q, first_fail_d;
    logic                    any_fail_q, any_fail_d;
    logic                    pass_q, pass_d;

    logic [OP_BITS-1:0]      op_a, op_b;
    logic [OUT_BITS:0]       exact_w, approx_w, diff_w;
    logic [OUT_BITS-1:0]     err_w;

    // Error of the current vector against the combinational DUT response.
    always_comb begin
        op_a     = vec_q[OP_BITS-1:0];
        op_b     = vec_q[IN_BITS-1:OP_BITS];
        exact_w  = (OUT_BITS+1)'(op_a) + (OUT_BITS+1)'(op_b);
        approx_w = {1'b0, dut_out};
        diff_w   = (approx_w >= exact_w) ? (approx_w - exact_w) : (exact_w - approx_w);
        err_w    = diff_w[OUT_BITS-1:0];
    end

    // NOTE: every next-state variable takes its held value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        max_err_d    = max_err_q;
        err_count_d  = err_count_q;
        err_sum_d    = err_sum_q;
        first_fail_d = first_fail_q;
        any_fail_d   = any_fail_q;
        pass_d       = pass_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    vec_d        = '0;
                    max_err_d    = '0;
                    err_count_d  = '0;
                    err_sum_d    = '0;
                    first_fail_d = '0;
                    any_fail_d   = 1'b0;
                    pass_d       = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (err_w > max_err_q) begin
                    max_err_d = err_w;
                end
                if (err_w != '0) begin
                    err_count_d = err_count_q + (IN_BITS+1)'(1);
                    err_sum_d   = err_sum_q + SUM_W'(err_w);
                    if (!any_fail_q) begin
                        any_fail_d   = 1'b1;
                        first_fail_d = vec_q;
                    end
                end
                // The verdict uses the metric already updated with the last vector.
                if (vec_q == '1) begin
                    state_d = ST_DONE;
                    pass_d  = ({{(32-OUT_BITS){1'b0}}, max_err_d} <= ET_U);
                end else begin
                    vec_d = vec_q + IN_BITS'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            max_err_q    <= '0;
            err_count_q  <= '0;
            err_sum_q    <= '0;
            first_fail_q <= '0;
            any_fail_q   <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            max_err_q    <= max_err_d;
            err_count_q  <= err_count_d;
            err_sum_q    <= err_sum_d;
            first_fail_q <= first_fail_d;
            any_fail_q   <= any_fail_d;
            pass_q       <= pass_d;
        end
    end

    assign dut_in     = (state_q == ST_RUN) ? vec_q : '0;
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign max_err    = max_err_q;
    assign err_count  = err_count_q;
    assign err_sum    = err_sum_q;
    assign first_fail = first_fail_q;
    assign any_fail   = any_fail_q;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Randomized self-checking bench: stand-in approximate adders are swept and the
// monitor's metrics are compared with an arithmetic reference computed per sweep.
module tb_approx_adder_error_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] dut_in, dut_in_b;
    logic [2:0] dut_out, dut_out_b;
    logic       busy, done, pass, any_fail;
    logic       busy_b, done_b, pass_b, any_fail_b;
    logic [2:0] max_err, max_err_b;
    logic [4:0] err_count, err_count_b;
    logic [6:0] err_sum, err_sum_b;
    logic [3:0] first_fail, first_fail_b;

    int         total = 0;
    int         bad = 0;
    int         mode = 0;          // 0 exact, 1 tied to 0, 2 out2 forced 0, 3 random table
    logic [2:0] lut [16];

    always #5 clk = ~clk;

    approx_adder_error_monitor #(.IN_BITS(4), .OUT_BITS(3), .ET(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .max_err(max_err),
        .err_count(err_count), .err_sum(err_sum), .first_fail(first_fail),
        .any_fail(any_fail)
    );

    approx_adder_error_monitor #(.IN_BITS(4), .OUT_BITS(3), .ET(4)) u_dut_et4 (
        .clk(clk), .rst(rst), .start(start), .dut_in(dut_in_b), .dut_out(dut_out_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .max_err(max_err_b),
        .err_count(err_count_b), .err_sum(err_sum_b), .first_fail(first_fail_b),
        .any_fail(any_fail_b)
    );

    function automatic logic [2:0] circuit(input int m, input logic [3:0] v);
        logic [2:0] s;
        s = {1'b0, v[1:0]} + {1'b0, v[3:2]};
        case (m)
            0:       return s;
            1:       return 3'd0;
            2:       return {1'b0, s[1:0]};
            default: return lut[v];
        endcase
    endfunction

    always_comb dut_out   = circuit(mode, dut_in);
    always_comb dut_out_b = circuit(mode, dut_in_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference metrics straight from the definition: |approx - (a+b)| over all 16 vectors.
    int m_max, m_cnt, m_sum, m_first, m_any;
    task automatic model();
        m_max = 0; m_cnt = 0; m_sum = 0; m_first = 0; m_any = 0;
        for (int v = 0; v < 16; v++) begin
            int e;
            e = int'(circuit(mode, 4'(v))) - ((v % 4) + (v / 4));
            if (e < 0) e = -e;
            if (e > m_max) m_max = e;
            if (e != 0) begin
                m_cnt++;
                m_sum += e;
                if (m_any == 0) m_first = v;
                m_any = 1;
            end
        end
    endtask

    task automatic check_results();
        model();
        check("max_err",    max_err,    m_max);
        check("err_count",  err_count,  m_cnt);
        check("err_sum",    err_sum,    m_sum);
        check("first_fail", first_fail, m_first);
        check("any_fail",   any_fail,   m_any);
        check("pass_et3",   pass,       (m_max <= 3) ? 1 : 0);
        check("done_et4",   done_b,     1);
        check("pass_et4",   pass_b,     (m_max <= 4) ? 1 : 0);
    endtask

    // One sweep: optional extra start pulse at cycle restart_at, optional start held through done.
    task automatic sweep(input bit pre_started, input int restart_at, input bit hold_at_done);
        int cycles;
        int k;
        if (!pre_started) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        cycles = 1;
        k = 0;
        while (!done && cycles < 64) begin
            check("busy_run", busy, 1);
            check("dut_in_run", dut_in, k);
            start = (cycles == restart_at);
            k++;
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check("sweep_len", cycles, 17);
        check("done_seen", done, 1);
        check("busy_done", busy, 0);
        check("dut_in_done", dut_in, 0);
        check_results();
        if (hold_at_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("restart_busy", busy, 1);
            check("restart_done", done, 0);
            check("restart_cnt", err_count, 0);
            check("restart_max", max_err, 0);
            check("restart_any", any_fail, 0);
            check("restart_pass", pass, 0);
        end else begin
            @(negedge clk);
            check("done_once", done, 0);
            check("idle_busy", busy, 0);
            check("idle_dut_in", dut_in, 0);
            check("pass_held", pass, (m_max <= 3) ? 1 : 0);
            check("sum_held", err_sum, m_sum);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) lut[i] = 3'(i % 8);
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_sum", err_sum, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_dut_in0", dut_in, 0);
        check("idle_busy0", busy, 0);

        mode = 0; sweep(1'b0, 0, 1'b0);
        mode = 1; sweep(1'b0, 0, 1'b0);
        mode = 2; sweep(1'b0, 0, 1'b0);

        // Extra start mid-sweep is ignored; then back-to-back restart held through done.
        mode = 1; sweep(1'b0, 5, 1'b1);
        sweep(1'b1, 0, 1'b0);

        // Asynchronous reset in the middle of a sweep discards partial results.
        mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dut_in", dut_in, 0);
        check("mid_rst_sum", err_sum, 0);
        check("mid_rst_cnt", err_count, 0);
        check("mid_rst_max", max_err, 0);
        check("mid_rst_any", any_fail, 0);
        check("mid_rst_first", first_fail, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", busy, 0);
        sweep(1'b0, 0, 1'b0);

        mode = 3;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) lut[i] = 3'($urandom_range(7, 0));
            sweep(1'b0, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
